// File: rtl/rtrace_pkg.sv
// Shared types and constants for the retire trace capture block.
// Optional load-byte logging is selected with RTRACE_LOG_LOADS_EN.
package rtrace_pkg;

  localparam int RTRACE_LOG_DEPTH_DEFAULT = 32;
  localparam int RTRACE_LANES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        valid;
  } rtrace_entry_t;

  // Byte address of one lane; wraps mod 2^32.
  function automatic logic [31:0] rtrace_byte_addr(
    input logic [31:0] base,
    input int unsigned lane
  );
    return base + 32'(lane);
  endfunction

endpackage

// File: rtl/rtrace_byte_log.sv
// Byte-granular log of touched memory: CAM hit search,
// ordered 4-lane allocation, entry count and sticky overflow.
module rtrace_byte_log
  import rtrace_pkg::*;
#(
  parameter  int DEPTH = RTRACE_LOG_DEPTH_DEFAULT,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      valid_i,
  input  logic [31:0]               addr_i,
  input  logic [RTRACE_LANES-1:0]   lane_en_i,
  input  logic [RTRACE_LANES-1:0][7:0] lane_data_i,
  output rtrace_entry_t [DEPTH-1:0] entries_o,
  output logic [CW-1:0]             count_o,
  output logic                      overflow_o
);

  rtrace_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [31:0]               ba;
  logic                      hit;

  // Lanes are processed in ascending order on the working copy,
  // so later lanes see entries allocated by earlier ones.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    ba    = '0;
    hit   = 1'b0;
    if (clear_i) begin
      ent_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (valid_i) begin
      for (int b = 0; b < RTRACE_LANES; b++) begin
        if (lane_en_i[b]) begin
          ba  = rtrace_byte_addr(addr_i, b);
          hit = 1'b0;
          for (int i = 0; i < DEPTH; i++) begin
            if (!hit && ent_d[i].valid &&
                ent_d[i].addr == ba) begin
              ent_d[i].data = lane_data_i[b];
              hit = 1'b1;
            end
          end
          if (!hit) begin
            if (cnt_d == CW'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_d) begin
                  ent_d[i].addr  = ba;
                  ent_d[i].data  = lane_data_i[b];
                  ent_d[i].valid = 1'b1;
                end
              end
              cnt_d = cnt_d + CW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign entries_o  = ent_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/retire_trace_capture.sv
// Retire snapshot producer: retire strobe, shadow regfile, byte log.
// Define RTRACE_LOG_LOADS_EN to also log load bytes.
module retire_trace_capture
  import rtrace_pkg::*;
#(
  parameter  int LOG_DEPTH = RTRACE_LOG_DEPTH_DEFAULT,
  localparam int CW        = $clog2(LOG_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      rvfi_valid_i,
  input  logic [31:0]               rvfi_insn_i,
  input  logic [4:0]                rvfi_rd_addr_i,
  input  logic [31:0]               rvfi_rd_wdata_i,
  input  logic [31:0]               rvfi_mem_addr_i,
  input  logic [3:0]                rvfi_mem_rmask_i,
  input  logic [3:0]                rvfi_mem_wmask_i,
  input  logic [31:0]               rvfi_mem_rdata_i,
  input  logic [31:0]               rvfi_mem_wdata_i,
  output logic                      retire_o,
  output logic [31:0]               instr_o,
  output logic [31:0][31:0]         regfile_o,
  output logic [LOG_DEPTH-1:0][31:0] mem_addr_o,
  output logic [LOG_DEPTH-1:0][7:0] mem_data_o,
  output logic [CW-1:0]             log_count_o,
  output logic                      overflow_o
);

  logic                        retire_q;
  logic [31:0]                 instr_q;
  logic [31:0][31:0]           rf_q;
  logic [RTRACE_LANES-1:0]     lane_en;
  logic [RTRACE_LANES-1:0][7:0] lane_data;
  rtrace_entry_t [LOG_DEPTH-1:0] entries;

`ifdef RTRACE_LOG_LOADS_EN
  // Store data wins when a lane is both read and written.
  always_comb begin
    lane_en   = rvfi_mem_wmask_i | rvfi_mem_rmask_i;
    lane_data = '0;
    for (int b = 0; b < RTRACE_LANES; b++) begin
      lane_data[b] = rvfi_mem_wmask_i[b] ?
                     rvfi_mem_wdata_i[8*b +: 8] :
                     rvfi_mem_rdata_i[8*b +: 8];
    end
  end
`else
  logic unused_load_sigs;
  assign unused_load_sigs = ^{rvfi_mem_rmask_i, rvfi_mem_rdata_i};

  always_comb begin
    lane_en   = rvfi_mem_wmask_i;
    lane_data = rvfi_mem_wdata_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_q <= 1'b0;
      instr_q  <= '0;
      rf_q     <= '0;
    end else begin
      retire_q <= rvfi_valid_i;
      if (rvfi_valid_i) begin
        instr_q <= rvfi_insn_i;
        if (rvfi_rd_addr_i != 5'd0) begin
          rf_q[rvfi_rd_addr_i] <= rvfi_rd_wdata_i;
        end
      end
    end
  end

  rtrace_byte_log #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .valid_i     (rvfi_valid_i),
    .addr_i      (rvfi_mem_addr_i),
    .lane_en_i   (lane_en),
    .lane_data_i (lane_data),
    .entries_o   (entries),
    .count_o     (log_count_o),
    .overflow_o  (overflow_o)
  );

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int i = 0; i < LOG_DEPTH; i++) begin
      mem_addr_o[i] = entries[i].addr;
      mem_data_o[i] = entries[i].data;
    end
  end

  assign retire_o  = retire_q;
  assign instr_o   = instr_q;
  assign regfile_o = rf_q;

endmodule

// File: tb/tb_retire_trace_capture.sv
// Directed bench for retire_trace_capture with a queue-based
// reference model checked every cycle.
module tb_retire_trace_capture;

  localparam int D  = 32;
  localparam int CW = 6;
`ifdef RTRACE_LOG_LOADS_EN
  localparam bit LOADS = 1'b1;
`else
  localparam bit LOADS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni, clear_i, v;
  logic [31:0] insn, rd_wd, maddr, rdat, wdat;
  logic [4:0]  rd;
  logic [3:0]  rm, wm;
  logic              retire_o, overflow_o;
  logic [31:0]       instr_o;
  logic [31:0][31:0] regfile_o;
  logic [D-1:0][31:0] mem_addr_o;
  logic [D-1:0][7:0]  mem_data_o;
  logic [CW-1:0]      log_count_o;

  retire_trace_capture #(.LOG_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .rvfi_valid_i(v), .rvfi_insn_i(insn),
    .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(rd_wd),
    .rvfi_mem_addr_i(maddr),
    .rvfi_mem_rmask_i(rm), .rvfi_mem_wmask_i(wm),
    .rvfi_mem_rdata_i(rdat), .rvfi_mem_wdata_i(wdat),
    .retire_o(retire_o), .instr_o(instr_o),
    .regfile_o(regfile_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .log_count_o(log_count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [31:0] m_addr[$];
  logic [7:0]  m_data[$];
  logic [31:0] m_rf[32];
  logic [31:0] m_instr;
  bit          m_ret, m_ovf;

  task automatic model_reset();
    m_addr.delete();
    m_data.delete();
    foreach (m_rf[r]) m_rf[r] = '0;
    m_instr = '0;
    m_ret   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_apply();
    logic [31:0] a;
    logic [7:0]  d;
    int          idx;
    if (clear_i) begin
      m_addr.delete();
      m_data.delete();
      m_ovf = 1'b0;
    end
    m_ret = v;
    if (v) begin
      m_instr = insn;
      if (rd != 0) m_rf[rd] = rd_wd;
      for (int b = 0; b < 4; b++) begin
        if (wm[b] || (LOADS && rm[b])) begin
          a = maddr + b;
          d = wm[b] ? wdat[8*b +: 8] : rdat[8*b +: 8];
          idx = -1;
          for (int i = 0; i < m_addr.size(); i++)
            if (m_addr[i] == a) idx = i;
          if (idx >= 0) m_data[idx] = d;
          else if (m_addr.size() < D) begin
            m_addr.push_back(a);
            m_data.push_back(d);
          end else m_ovf = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("retire", retire_o, m_ret);
      chk("instr", instr_o, m_instr);
      chk("count", log_count_o, m_addr.size());
      chk("overflow", overflow_o, m_ovf);
      for (int r = 0; r < 32; r++)
        chk($sformatf("rf[%0d]", r), regfile_o[r], m_rf[r]);
      for (int i = 0; i < D; i++) begin
        chk($sformatf("addr[%0d]", i), mem_addr_o[i],
            (i < m_addr.size()) ? m_addr[i] : 32'h0);
        chk($sformatf("data[%0d]", i), mem_data_o[i],
            (i < m_data.size()) ? m_data[i] : 8'h0);
      end
    end
  end

  task automatic step(bit vv, bit clr, logic [31:0] ins,
                      logic [4:0] r, logic [31:0] wd,
                      logic [31:0] ad, logic [3:0] rmk,
                      logic [3:0] wmk, logic [31:0] rdt,
                      logic [31:0] wdt);
    v = vv; clear_i = clr; insn = ins; rd = r; rd_wd = wd;
    maddr = ad; rm = rmk; wm = wmk; rdat = rdt; wdat = wdt;
    @(posedge clk);
    model_apply();
    #2;
    v = 1'b0; clear_i = 1'b0; rm = '0; wm = '0;
  endtask

  task automatic sw(logic [31:0] ad, logic [31:0] dt);
    step(1, 0, 32'h00a12023, 0, 0, ad, 0, 4'hf, 0, dt);
  endtask

  task automatic idle(bit clr);
    step(0, clr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 0; v = 0; insn = 0; rd = 0;
    rd_wd = 0; maddr = 0; rm = 0; wm = 0; rdat = 0; wdat = 0;
    model_reset();
    #7;
    chk("rst_retire", retire_o, 0);
    chk("rst_count", log_count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_addr0", mem_addr_o[0], 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    sw(32'h100, 32'hAABBCCDD);
    chk("sw_retire", retire_o, 1);
    chk("sw_count", log_count_o, 4);
    chk("sw_addr1", mem_addr_o[1], 32'h101);
    chk("sw_data0", mem_data_o[0], 8'hDD);
    chk("sw_data1", mem_data_o[1], 8'hCC);
    chk("sw_data3", mem_data_o[3], 8'hAA);
    idle(0);
    chk("sw_pulse", retire_o, 0);

    step(1, 0, 32'h00b10123, 0, 0, 32'h100, 0, 4'b0100, 0,
         32'h0011_0000);
    chk("sb_data2", mem_data_o[2], 8'h11);
    chk("sb_count", log_count_o, 4);

    step(1, 0, 32'h00700293, 5, 7, 0, 0, 0, 0, 0);
    step(1, 0, 32'h00900013, 0, 9, 0, 0, 0, 0, 0);
    chk("rf5", regfile_o[5], 7);
    chk("rf0", regfile_o[0], 0);
    chk("instr", instr_o, 32'h00900013);

    idle(1);
    chk("clr_count", log_count_o, 0);
    chk("clr_rf5", regfile_o[5], 7);

    for (int k = 0; k < 7; k++)
      sw(32'h1000 + 16 * k, 32'h10203040 + k);
    step(1, 0, 32'h1, 0, 0, 32'h2000, 0, 4'b0011, 0, 32'h5566);
    step(1, 0, 32'h1, 0, 0, 32'h3000, 0, 4'b0001, 0, 32'h77);
    chk("fill_count", log_count_o, 31);
    chk("fill_ovf", overflow_o, 0);
    sw(32'h900, 32'h0403_02A5);
    chk("full_count", log_count_o, 32);
    chk("full_addr31", mem_addr_o[31], 32'h900);
    chk("full_data31", mem_data_o[31], 8'hA5);
    chk("full_ovf", overflow_o, 1);
    idle(0);
    sw(32'h1000, 32'hDEADBEEF);
    chk("ovf_sticky", overflow_o, 1);
    chk("full_hit", mem_data_o[0], 8'hEF);

    idle(1);
    chk("clr_ovf", overflow_o, 0);
    sw(32'hFFFF_FFFC, 32'h01020304);
    chk("wrap_addr3", mem_addr_o[3], 32'hFFFF_FFFF);
    step(1, 0, 32'h1, 0, 0, 32'hFFFF_FFFF, 0, 4'b0011, 0,
         32'h0000_BEEF);
    chk("wrap_count", log_count_o, 5);
    chk("wrap_addr4", mem_addr_o[4], 32'h0);
    chk("wrap_data4", mem_data_o[4], 8'hBE);
    chk("wrap_data3", mem_data_o[3], 8'hEF);

    step(1, 0, 32'h1, 0, 0, 32'h400, 4'b1111, 4'b0011,
         32'h99887766, 32'h0000_2211);
    step(1, 1, 32'h20002303, 6, 32'h12345678, 32'h200, 4'hF, 0,
         32'h12345678, 0);
    chk("clrlw_count", log_count_o, LOADS ? 4 : 0);
    chk("clrlw_ovf", overflow_o, 0);
    chk("clrlw_rf6", regfile_o[6], 32'h12345678);

    sw(32'h500, 32'h11223344);
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("arst_retire", retire_o, 0);
    chk("arst_count", log_count_o, 0);
    chk("arst_rf5", regfile_o[5], 0);
    chk("arst_instr", instr_o, 0);
    #8;
    rst_ni = 1'b1;
    sw(32'h600, 32'h55667788);
    chk("post_retire", retire_o, 1);
    chk("post_count", log_count_o, 4);
    chk("post_addr0", mem_addr_o[0], 32'h600);
    idle(0);
    idle(0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
